somador_multiciclo: RTL and testbench
=====================================

// Module: somador_multiciclo
// PURPOSE
//   Parametrised multi-cycle adder/subtractor: processes WIDTH-bit operands CHUNK bits per
//   clock through a ripple chain of full adders, with the carry held in a register between
//   chunks. Valid/ready handshakes on both sides; outputs carry, signed-overflow and zero
//   flags. Serves as the area-lean arithmetic unit in the datapath.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be a multiple of CHUNK
//   CHUNK  4   bits added per cycle; N = WIDTH/CHUNK cycles per operation (CHUNK=WIDTH gives N=1)
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand set valid
//   in_ready   out  1      block can accept operands (state IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in (add) / borrow-in (sub)
//   sub        in   1      0: s = a + b + cin ; 1: s = a - b - cin
//   out_valid  out  1      result and flags valid
//   out_ready  in   1      consumer accepts result
//   s          out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1 (sub: 1 = no borrow)
//   ovf        out  1      signed (two's complement) overflow
//   zero       out  1      1 when s == 0
// BEHAVIOUR
//   Reset (rst=1 at an edge): state IDLE; s, cout, ovf, zero, out_valid = 0; chunk counter and
//     carry register = 0; in_ready=1 from the next cycle. Any in-flight operation is discarded.
//   FSM IDLE -> CALC -> DONE -> IDLE:
//     IDLE: in_ready=1. Edge with in_valid&&in_ready: capture a, b^{WIDTH{sub}}, carry
//       register = cin^sub, counter=0, go CALC. in_valid=0: stay.
//     CALC: in_ready=0. Each edge adds chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of captured
//       operands plus carry register, writes that slice of s, updates carry register, k++.
//       On the edge processing k=N-1: latch cout = final carry, ovf = carry-into-MSB XOR
//       carry-out-of-MSB, zero = (full s == 0), go DONE.
//     DONE: out_valid=1; s/cout/ovf/zero held stable. Edge with out_ready=1: out_valid=0,
//       go IDLE. out_ready=0: hold indefinitely (backpressure).
//   Latency: acceptance edge E0; out_valid high in the cycle after edge E0+N (N edges of CALC).
//     Throughput: one operation per N+2 cycles with out_ready held high.
//   No overlap: in_valid during CALC/DONE is ignored, never queued. Port changes on a, b, cin,
//     sub after acceptance do not affect the result.
//   s, flags are not guaranteed meaningful while out_valid=0; they are updated only in CALC.
//   Simultaneous out_ready and in_valid in DONE: only output handshake happens; input is
//     accepted no earlier than the following IDLE cycle.
//   rst overrides every other input in every state.
// TESTING (WIDTH=16, CHUNK=4 unless stated)
//   1 Reset: hold rst 2 cycles -> out_valid=0, s=0, cout=ovf=zero=0, in_ready=1 after release.
//   2 Add a=0x0008 b=0x000A cin=0 sub=0 -> s=0x0012 cout=0 ovf=0 zero=0; out_valid exactly
//     in cycle after edge E0+4; in_ready=0 during CALC/DONE.
//   3 Add a=0xFFFF b=0x0001 cin=0 -> s=0x0000 cout=1 zero=1 ovf=0; a=0x7FFF b=0x0001 ->
//     s=0x8000 cout=0 ovf=1.
//   4 Sub a=0x0005 b=0x0007 cin=0 -> s=0xFFFE cout=0 ovf=0; a=0x8000 b=0x0001 cin=0 ->
//     s=0x7FFF cout=1 ovf=1; a=0x0005 b=0x0003 cin=1 -> s=0x0001 cout=1.
//   5 Backpressure: out_ready=0 for 5 cycles after out_valid, toggle a/b and pulse in_valid ->
//     s/flags stable, in_ready=0, no second op; out_ready=1 -> out_valid=0, in_ready=1 next.
//   6 rst=1 on 2nd CALC cycle -> next cycle out_valid=0, in_ready=1; following op a=0x1234
//     b=0x4321 -> s=0x5555 (no residue). Repeat test 2 with CHUNK=16 (N=1) and CHUNK=1 (N=16).

Source files
------------

// File: rtl/somador_multiciclo.sv
// -----------------------------------------------------------------------------
// somador_multiciclo
//
// Multi-cycle adder/subtractor. A WIDTH-bit operation is processed CHUNK bits
// per clock through a ripple chain of full adders. A register carries the
// chunk-to-chunk carry, so one operation takes N = WIDTH/CHUNK CALC cycles.
// Subtraction is done as a + ~b + !borrow_in: B is inverted and the carry
// register is loaded with cin^sub when the operands are captured.
//
// Parameters
//   WIDTH  operand/result width (must be a multiple of CHUNK)
//   CHUNK  bits added per clock (CHUNK == WIDTH gives a single CALC cycle)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset, overrides everything
//   in_valid   operand set valid
//   in_ready   block idle and able to accept operands
//   a, b       operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: s = a + b + cin, 1: s = a - b - cin
//   out_valid  result and flags valid, held until out_ready
//   out_ready  consumer accepts the result
//   s          result modulo 2^WIDTH
//   cout       carry out of the MSB (for sub: 1 means no borrow)
//   ovf        two's-complement overflow
//   zero       result is zero
// -----------------------------------------------------------------------------
module somador_multiciclo #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;       // already inverted for subtraction
    logic [WIDTH-1:0] s_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             zero_reg;

    // Chunk datapath
    logic [N-1:0]     chunk_hit;   // one-hot decode of the chunk counter
    logic [CHUNK-1:0] a_sel;
    logic [CHUNK-1:0] b_sel;
    logic [CHUNK-1:0] sum;
    logic             carry_msb;   // carry into the top bit of the chunk
    logic             carry_out;   // carry out of the top bit of the chunk
    logic [WIDTH-1:0] s_next;      // s with the current chunk merged in

    // -------------------------------------------------------------------------
    // Chunk counter decode
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_hit
            localparam logic [CW-1:0] IDX = CW'(gi);
            assign chunk_hit[gi] = (cnt_reg == IDX);
        end
    endgenerate

    // Operand chunk selection as an AND-OR mux over the one-hot decode.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (chunk_hit[k]) begin
                a_sel = a_sel | a_reg[k*CHUNK +: CHUNK];
                b_sel = b_sel | b_reg[k*CHUNK +: CHUNK];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Ripple chain of CHUNK full adders fed by the carry register.
    // carry_msb is captured before the last stage so that on the final chunk
    // it is the carry into bit WIDTH-1, used for the signed overflow flag.
    // -------------------------------------------------------------------------
    always_comb begin
        logic cy;
        cy        = carry_reg;
        carry_msb = carry_reg;
        sum       = '0;
        for (int i = 0; i < CHUNK; i++) begin
            carry_msb = cy;
            sum[i]    = a_sel[i] ^ b_sel[i] ^ cy;
            cy        = (a_sel[i] & b_sel[i]) | (cy & (a_sel[i] ^ b_sel[i]));
        end
        carry_out = cy;
    end

    // Merge the freshly computed chunk into the result so that the zero flag
    // on the last edge sees the complete value.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_merge
            assign s_next[gi*CHUNK +: CHUNK] =
                chunk_hit[gi] ? sum : s_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            s_reg         <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            zero_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // in_ready_reg is 1 throughout IDLE
                    if (in_valid) begin
                        a_reg        <= a;
                        b_reg        <= b ^ {WIDTH{sub}};
                        carry_reg    <= cin ^ sub;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= CALC;
                    end
                end

                CALC: begin
                    s_reg     <= s_next;
                    carry_reg <= carry_out;
                    if (cnt_reg == LAST_IDX) begin
                        cnt_reg       <= '0;
                        cout_reg      <= carry_out;
                        ovf_reg       <= carry_out ^ carry_msb;
                        zero_reg      <= (s_next == '0);
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end

                DONE: begin
                    // A simultaneous in_valid is ignored here; the next
                    // operand set is taken no earlier than the following IDLE.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign s         = s_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_somador_multiciclo.sv
// -----------------------------------------------------------------------------
// tb_somador_multiciclo
//
// Drives three instances of somador_multiciclo (WIDTH=16 with CHUNK=4, 16, 1).
// Inputs are driven and outputs sampled on the falling clock edge. Expected
// results come from an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_somador_multiciclo;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;

    logic        in_valid_w  [3];
    logic        in_ready_w  [3];
    logic        out_valid_w [3];
    logic [15:0] s_w         [3];
    logic        cout_w      [3];
    logic        ovf_w       [3];
    logic        zero_w      [3];

    int n_of [3] = '{4, 1, 16};

    int passed = 0;
    int failed = 0;
    int total  = 0;

    somador_multiciclo #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w[0]), .in_ready(in_ready_w[0]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_w[0]),
        .out_ready(out_ready), .s(s_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]),
        .zero(zero_w[0])
    );

    somador_multiciclo #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w[1]), .in_ready(in_ready_w[1]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_w[1]),
        .out_ready(out_ready), .s(s_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]),
        .zero(zero_w[1])
    );

    somador_multiciclo #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w[2]), .in_ready(in_ready_w[2]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_w[2]),
        .out_ready(out_ready), .s(s_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]),
        .zero(zero_w[2])
    );

    // Reference: exact integer arithmetic, then reduce modulo 2^16.
    function automatic void model(input logic [15:0] ta, input logic [15:0] tb_v,
                                  input logic tc, input logic ts,
                                  output logic [15:0] es, output logic ec,
                                  output logic eo, output logic ez);
        int r;
        int sr;
        if (!ts) begin
            r  = int'(ta) + int'(tb_v) + int'(tc);
            sr = int'($signed(ta)) + int'($signed(tb_v)) + int'(tc);
            ec = (r > 65535);
        end else begin
            r  = int'(ta) - int'(tb_v) - int'(tc);
            sr = int'($signed(ta)) - int'($signed(tb_v)) - int'(tc);
            ec = (r >= 0);
        end
        es = r[15:0];
        eo = (sr > 32767) || (sr < -32768);
        ez = (es == 16'h0000);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One operation on instance w; optionally completes the output handshake.
    task automatic run_op(input int w, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tc, input logic ts, input bit release_out,
                          input string tag);
        logic [15:0] es;
        logic        ec, eo, ez;
        int          guard;
        int          lat;
        bit          ready_seen;
        model(ta, tb_v, tc, ts, es, ec, eo, ez);

        guard = 0;
        while (!in_ready_w[w] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, ":in_ready"}, 32'(in_ready_w[w]), 32'd1);

        a = ta; b = tb_v; cin = tc; sub = ts;
        in_valid_w[w] = 1'b1;
        @(negedge clk);                       // acceptance edge E0 has passed
        in_valid_w[w] = 1'b0;
        // Port changes after acceptance must not matter.
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);

        lat = 0;
        ready_seen = 1'b0;
        while (!out_valid_w[w] && lat < 40) begin
            if (in_ready_w[w]) ready_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        check({tag, ":latency"},     32'(lat),             32'(n_of[w]));
        check({tag, ":ready_calc"},  32'(ready_seen),      32'd0);
        check({tag, ":ready_done"},  32'(in_ready_w[w]),   32'd0);
        check({tag, ":s"},           32'(s_w[w]),          32'(es));
        check({tag, ":cout"},        32'(cout_w[w]),       32'(ec));
        check({tag, ":ovf"},         32'(ovf_w[w]),        32'(eo));
        check({tag, ":zero"},        32'(zero_w[w]),       32'(ez));
        $display("op %s inst=%0d a=%h b=%h cin=%0d sub=%0d -> s=%h cout=%0d ovf=%0d zero=%0d lat=%0d",
                 tag, w, ta, tb_v, tc, ts, s_w[w], cout_w[w], ovf_w[w], zero_w[w], lat);

        if (release_out) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check({tag, ":ov_clear"},  32'(out_valid_w[w]), 32'd0);
            check({tag, ":ready_ret"}, 32'(in_ready_w[w]),  32'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] es;
        logic        ec, eo, ez;

        rst = 1'b1; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < 3; i++) in_valid_w[i] = 1'b0;

        // Reset held for two cycles
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset%0d:out_valid", i), 32'(out_valid_w[i]), 32'd0);
            check($sformatf("reset%0d:in_ready", i),  32'(in_ready_w[i]),  32'd1);
            check($sformatf("reset%0d:s", i),         32'(s_w[i]),         32'd0);
            check($sformatf("reset%0d:flags", i),
                  32'({cout_w[i], ovf_w[i], zero_w[i]}), 32'd0);
            $display("reset inst=%0d out_valid=%0d in_ready=%0d s=%h",
                     i, out_valid_w[i], in_ready_w[i], s_w[i]);
        end

        // Directed vectors
        run_op(0, 16'h0008, 16'h000A, 1'b0, 1'b0, 1'b1, "add_basic");
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, "add_wrap");
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, "add_ovf");
        run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, "sub_neg");
        run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, "sub_ovf");
        run_op(0, 16'h0005, 16'h0003, 1'b1, 1'b1, 1'b1, "sub_borrow");
        run_op(0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, "add_cin_wrap");

        // Backpressure: result held, inputs ignored while in DONE
        run_op(0, 16'h1357, 16'h2468, 1'b1, 1'b0, 1'b0, "bp");
        model(16'h1357, 16'h2468, 1'b1, 1'b0, es, ec, eo, ez);
        for (int i = 0; i < 5; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            in_valid_w[0] = (i % 2 == 0);
            @(negedge clk);
            check($sformatf("bp%0d:s", i),         32'(s_w[0]),         32'(es));
            check($sformatf("bp%0d:flags", i),
                  32'({cout_w[0], ovf_w[0], zero_w[0]}), 32'({ec, eo, ez}));
            check($sformatf("bp%0d:out_valid", i), 32'(out_valid_w[0]), 32'd1);
            check($sformatf("bp%0d:in_ready", i),  32'(in_ready_w[0]),  32'd0);
            $display("bp cycle %0d s=%h out_valid=%0d in_ready=%0d",
                     i, s_w[0], out_valid_w[0], in_ready_w[0]);
        end
        // out_ready and in_valid together: only the output handshake happens
        in_valid_w[0] = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid_w[0] = 1'b0;
        out_ready = 1'b0;
        check("bp_release:out_valid", 32'(out_valid_w[0]), 32'd0);
        check("bp_release:in_ready",  32'(in_ready_w[0]),  32'd1);
        repeat (2) @(negedge clk);
        check("bp_noqueue:in_ready",  32'(in_ready_w[0]),  32'd1);
        check("bp_noqueue:out_valid", 32'(out_valid_w[0]), 32'd0);
        $display("bp release out_valid=%0d in_ready=%0d", out_valid_w[0], in_ready_w[0]);

        // Reset during the second CALC cycle
        a = 16'hABCD; b = 16'h1111; cin = 1'b1; sub = 1'b0;
        in_valid_w[0] = 1'b1;
        @(negedge clk);                       // first CALC cycle
        in_valid_w[0] = 1'b0;
        @(negedge clk);                       // second CALC cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst:out_valid", 32'(out_valid_w[0]), 32'd0);
        check("midrst:in_ready",  32'(in_ready_w[0]),  32'd1);
        check("midrst:s",         32'(s_w[0]),         32'd0);
        $display("midrst out_valid=%0d in_ready=%0d s=%h", out_valid_w[0], in_ready_w[0], s_w[0]);
        run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, "after_rst");

        // Same basic op on single-cycle and bit-serial instances
        run_op(1, 16'h0008, 16'h000A, 1'b0, 1'b0, 1'b1, "n1_basic");
        run_op(2, 16'h0008, 16'h000A, 1'b0, 1'b0, 1'b1, "n16_basic");

        // Randomized operations
        for (int i = 0; i < 16; i++)
            run_op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1,
                   $sformatf("rnd4_%0d", i));
        for (int i = 0; i < 4; i++) begin
            run_op(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1,
                   $sformatf("rnd16_%0d", i));
            run_op(2, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1,
                   $sformatf("rnd1_%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
